button_debounce: RTL and testbench



---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_channel.sv | 94 +++++++++
 rtl/button_debounce.sv | 57 +++++
 tb/tb_button_debounce.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared state encoding and default parameter values for the push-button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW,
    QUAL_HIGH,
    HELD_HIGH,
    QUAL_LOW
  } deb_state_t;

  localparam int DEFAULT_NUM_BUTTONS  = 2;
  localparam int DEFAULT_TICK_DIVIDE  = 200000;
  localparam int DEFAULT_STABLE_TICKS = 10;

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-flop synchronizer, qualification FSM with tick counter,
// and registered press/release pulses aligned with the first cycle of the new level.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_async,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  if (STABLE_TICKS < 1) begin : g_bad_stable_ticks
    $error("debounce_channel: STABLE_TICKS must be >= 1");
  end

  logic          sync_meta;
  logic          sync_out;
  deb_state_t    state;
  deb_state_t    next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta   <= 1'b0;
      sync_out    <= 1'b0;
      state       <= IDLE_LOW;
      cnt         <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      sync_meta   <= btn_async;
      sync_out    <= sync_meta;
      state       <= next_state;
      cnt         <= cnt_next;
      btn_press   <= (state == QUAL_HIGH) && (next_state == HELD_HIGH);
      btn_release <= (state == QUAL_LOW) && (next_state == IDLE_LOW);
    end
  end

  // A sample mismatch takes priority over a coincident tick.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      IDLE_LOW: begin
        if (sync_out) begin
          next_state = QUAL_HIGH;
          cnt_next   = '0;
        end
      end
      QUAL_HIGH: begin
        if (!sync_out) begin
          next_state = IDLE_LOW;
          cnt_next   = '0;
        end else if (tick) begin
          cnt_next = cnt + CNT_ONE;
          if (cnt == CNT_LAST) next_state = HELD_HIGH;
        end
      end
      HELD_HIGH: begin
        if (!sync_out) begin
          next_state = QUAL_LOW;
          cnt_next   = '0;
        end
      end
      QUAL_LOW: begin
        if (sync_out) begin
          next_state = HELD_HIGH;
          cnt_next   = '0;
        end else if (tick) begin
          cnt_next = cnt + CNT_ONE;
          if (cnt == CNT_LAST) next_state = IDLE_LOW;
        end
      end
      default: begin
        next_state = IDLE_LOW;
        cnt_next   = '0;
      end
    endcase
  end

  assign btn_level = (state == HELD_HIGH) || (state == QUAL_LOW);

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button debouncer: one shared sample-tick prescaler feeding
// NUM_BUTTONS independent debounce channels.
module button_debounce
  import debounce_pkg::*;
#(
  parameter int NUM_BUTTONS  = DEFAULT_NUM_BUTTONS,
  parameter int TICK_DIVIDE  = DEFAULT_TICK_DIVIDE,
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_in,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release,
  output logic                   tick
);

  localparam int PW = $clog2(TICK_DIVIDE);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIVIDE - 1);

  if (NUM_BUTTONS < 1) begin : g_bad_num_buttons
    $error("button_debounce: NUM_BUTTONS must be >= 1");
  end
  if (TICK_DIVIDE < 2) begin : g_bad_tick_divide
    $error("button_debounce: TICK_DIVIDE must be >= 2");
  end

  logic [PW-1:0] prescale_cnt;

  // tick is registered, so it lands the cycle after the counter hits its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_cnt <= '0;
      tick         <= 1'b0;
    end else begin
      prescale_cnt <= (prescale_cnt == PRESC_LAST) ? '0 : prescale_cnt + PRESC_ONE;
      tick         <= (prescale_cnt == PRESC_LAST);
    end
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .btn_async  (btn_in[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed self-checking bench for button_debounce with TICK_DIVIDE=4, STABLE_TICKS=3,
// two channels; outputs are sampled on the falling clock edge.
module tb_button_debounce;

  logic       clk;
  logic       reset;
  logic [1:0] btn_in;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic       tick;

  int n_compared   = 0;
  int n_mismatched = 0;

  int         cyc;
  int         tick_first;
  int         tick_cnt;
  int         press_first[2];
  int         press_cnt[2];
  int         rel_first[2];
  int         rel_cnt[2];
  int         level_high_cnt[2];
  int         press_both_cnt;
  int         overlap_total = 0;
  logic [1:0] rel_vec_first;

  button_debounce #(
    .NUM_BUTTONS (2),
    .TICK_DIVIDE (4),
    .STABLE_TICKS(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .tick       (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clearStats();
    cyc            = 0;
    tick_first     = -1;
    tick_cnt       = 0;
    press_both_cnt = 0;
    rel_vec_first  = 2'b00;
    for (int c = 0; c < 2; c++) begin
      press_first[c]    = -1;
      press_cnt[c]      = 0;
      rel_first[c]      = -1;
      rel_cnt[c]        = 0;
      level_high_cnt[c] = 0;
    end
  endtask

  // Drive pins/reset, then watch n falling edges; cycle indices count edges since the drive.
  task automatic applyStimulus(input logic [1:0] btn, input logic rst, input int n);
    btn_in = btn;
    reset  = rst;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (tick === 1'b1) begin
        tick_cnt++;
        if (tick_first < 0) tick_first = cyc;
      end
      for (int c = 0; c < 2; c++) begin
        if (btn_press[c] === 1'b1) begin
          press_cnt[c]++;
          if (press_first[c] < 0) press_first[c] = cyc;
        end
        if (btn_release[c] === 1'b1) begin
          rel_cnt[c]++;
          if (rel_first[c] < 0) rel_first[c] = cyc;
        end
        if (btn_press[c] === 1'b1 && btn_release[c] === 1'b1) overlap_total++;
        if (btn_level[c] === 1'b1) level_high_cnt[c]++;
      end
      if (btn_press === 2'b11) press_both_cnt++;
      if (btn_release !== 2'b00 && rel_vec_first === 2'b00) rel_vec_first = btn_release;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkRange(input string tag, input int observed, input int lo, input int hi);
    n_compared++;
    assert (observed >= lo && observed <= hi)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, observed, lo, hi);
    end
  endtask

  initial begin
    btn_in = 2'b00;
    reset  = 1'b1;

    $display("[TB] reset with both buttons held");
    clearStats();
    applyStimulus(2'b11, 1'b1, 3);
    checkOutput("reset_outputs", {25'd0, btn_level, btn_press, btn_release, tick}, 32'd0);
    checkOutput("reset_tick_cnt", tick_cnt, 0);
    checkOutput("reset_press_cnt", press_cnt[0] + press_cnt[1], 0);
    checkOutput("reset_level_cnt", level_high_cnt[0] + level_high_cnt[1], 0);

    clearStats();
    applyStimulus(2'b11, 1'b0, 20);
    checkOutput("first_tick", tick_first, 4);
    checkOutput("tick_count_20", tick_cnt, 5);
    checkOutput("post_reset_press_cnt0", press_cnt[0], 1);
    checkOutput("post_reset_press_cnt1", press_cnt[1], 1);
    checkOutput("post_reset_press_both", press_both_cnt, 1);
    checkRange("post_reset_press_time", press_first[0], 11, 15);
    checkOutput("post_reset_rel_cnt", rel_cnt[0] + rel_cnt[1], 0);
    checkOutput("post_reset_level", btn_level, 2'b11);

    clearStats();
    applyStimulus(2'b00, 1'b0, 20);
    checkOutput("release_all_cnt0", rel_cnt[0], 1);
    checkOutput("release_all_cnt1", rel_cnt[1], 1);
    checkOutput("release_all_level", btn_level, 2'b00);

    $display("[TB] clean press and release on channel 0");
    clearStats();
    applyStimulus(2'b01, 1'b0, 20);
    checkOutput("press0_cnt", press_cnt[0], 1);
    checkRange("press0_time", press_first[0], 11, 15);
    checkOutput("press0_other_chan", press_cnt[1], 0);
    checkOutput("press0_no_release", rel_cnt[0] + rel_cnt[1], 0);
    checkOutput("press0_level", btn_level, 2'b01);

    clearStats();
    applyStimulus(2'b00, 1'b0, 20);
    checkOutput("release0_cnt", rel_cnt[0], 1);
    checkRange("release0_time", rel_first[0], 11, 15);
    checkOutput("release0_no_press", press_cnt[0] + press_cnt[1], 0);
    checkOutput("release0_level", btn_level, 2'b00);

    $display("[TB] bounce rejection on channel 0");
    clearStats();
    applyStimulus(2'b01, 1'b0, 5);
    applyStimulus(2'b00, 1'b0, 2);
    applyStimulus(2'b01, 1'b0, 5);
    applyStimulus(2'b00, 1'b0, 20);
    checkOutput("bounce_level_cnt", level_high_cnt[0], 0);
    checkOutput("bounce_press_cnt", press_cnt[0], 0);
    checkOutput("bounce_rel_cnt", rel_cnt[0], 0);

    $display("[TB] reset during qualification on channel 1");
    clearStats();
    applyStimulus(2'b10, 1'b0, 8);
    applyStimulus(2'b10, 1'b1, 1);
    checkOutput("midreset_press_cnt", press_cnt[1], 0);
    checkOutput("midreset_level_cnt", level_high_cnt[1], 0);
    checkOutput("midreset_level", btn_level, 2'b00);

    clearStats();
    applyStimulus(2'b10, 1'b0, 20);
    checkOutput("after_reset_press_cnt", press_cnt[1], 1);
    checkRange("after_reset_press_time", press_first[1], 11, 15);
    checkOutput("after_reset_level", btn_level, 2'b10);

    $display("[TB] simultaneous press, single-channel release");
    clearStats();
    applyStimulus(2'b00, 1'b0, 20);
    checkOutput("release1_cnt", rel_cnt[1], 1);

    clearStats();
    applyStimulus(2'b11, 1'b0, 20);
    checkOutput("simul_press_both", press_both_cnt, 1);
    checkOutput("simul_press_cnt0", press_cnt[0], 1);
    checkOutput("simul_press_cnt1", press_cnt[1], 1);
    checkOutput("simul_level", btn_level, 2'b11);

    clearStats();
    applyStimulus(2'b01, 1'b0, 20);
    checkOutput("simul_release_vec", rel_vec_first, 2'b10);
    checkOutput("simul_release_cnt0", rel_cnt[0], 0);
    checkOutput("simul_release_level", btn_level, 2'b01);

    checkOutput("press_release_overlap", overlap_total, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
